// File: rtl/fb_ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchroniser, 11-bit frame deframer and FWFT scan-code FIFO.
// Optional parity checking with sticky frame_err is enabled by defining FB_PS2_PARITY_CHECK_EN.
module fb_ps2_kbd_rx #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic       av,
    output logic [7:0] rd_data,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Pin synchronisers idle high so reset release never produces a fall strobe
    logic clk_s1, clk_s2, clk_hist;
    logic dat_s1, dat_s2;
    logic fall_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_hist <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_hist <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall_c = clk_hist & ~clk_s2;

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [TMO_W-1:0] tmo_q;
    logic             timeout_c;

    assign timeout_c = (state_q != IDLE) && !fall_c && (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = IDLE;
        end else if (fall_c) begin
            unique case (state_q)
                IDLE:    if (!dat_s2) state_d = DATA;
                DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    logic start_c, shift_c, par_ld_c, stop_c, frame_ok_c, push_c, ferr_set_c;

`ifdef FB_PS2_PARITY_CHECK_EN
    logic par_q;
`endif

    // Per-cycle datapath controls derived from the current state and the fall strobe
    always_comb begin
        start_c    = 1'b0;
        shift_c    = 1'b0;
        par_ld_c   = 1'b0;
        stop_c     = 1'b0;
        frame_ok_c = 1'b0;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        if (fall_c) begin
            start_c  = (state_q == IDLE) && !dat_s2;
            shift_c  = (state_q == DATA);
            par_ld_c = (state_q == PARITY);
            stop_c   = (state_q == STOP);
        end
`ifdef FB_PS2_PARITY_CHECK_EN
        frame_ok_c = dat_s2 && (^{shift_q, par_q});
        ferr_set_c = stop_c && !frame_ok_c;
`else
        frame_ok_c = dat_s2;
`endif
        push_c = stop_c && frame_ok_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            tmo_q     <= '0;
        end else begin
            if (start_c) begin
                bit_cnt_q <= 3'd0;
            end else if (shift_c) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (shift_c) begin
                shift_q <= {dat_s2, shift_q[7:1]};
            end
            if (fall_c || (state_q == IDLE)) begin
                tmo_q <= '0;
            end else if (tmo_q != TMO_LAST) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
        end
    end

`ifdef FB_PS2_PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (par_ld_c) begin
                par_q <= dat_s2;
            end
            if (ferr_set_c) begin
                frame_err <= 1'b1;
            end
        end
    end
`else
    assign frame_err = 1'b0;
`endif

    // Scan-code FIFO; a pop on a full FIFO frees the slot for a same-cycle push
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_c, full_c, wr_c, ovf_c;

    assign av     = (count_q != '0);
    assign pop_c  = rd_en && av;
    assign full_c = (count_q == FULL_CNT);
    assign wr_c   = push_c && (!full_c || pop_c);
    assign ovf_c  = push_c && full_c && !pop_c;

    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({wr_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (ovf_c) begin
                overflow <= 1'b1;
            end
        end
    end

    assign rd_data = av ? mem[rd_ptr_q] : 8'h00;

endmodule
